fifo_ptr_control: RTL
=====================

# fifo_ptr_control

Parametrised pointer-and-occupancy controller for a circular-buffer FIFO, handling both the write and read sides of a single-clock queue. Accepts raw write/read requests, qualifies them against occupancy, and issues registered RAM strobes with the matching addresses. Also reports full/empty status and overflow/underflow errors. Sits between the producer/consumer request logic and the FIFO storage array; the storage RAM itself is outside this block.

## Interface
- `DEPTH`, 16, number of FIFO entries; any integer ≥ 2, not restricted to powers of two.
- `AW`, `$clog2(DEPTH)`, address/pointer width.
- `CW`, `$clog2(DEPTH+1)`, occupancy count width.
- `AF_LEVEL`, `DEPTH-2`, almost-full threshold (only with `FIFO_CTRL_ALMOST_EN`).
- `AE_LEVEL`, 2, almost-empty threshold (only with `FIFO_CTRL_ALMOST_EN`).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous reset, active-low.
- `write_en`  in  1  write request.
- `read_en`  in  1  read request.
- `write_en_o`  out  1  RAM write strobe.
- `wr_addr`  out  AW  RAM write address, valid with `write_en_o`.
- `read_en_o`  out  1  RAM read strobe.
- `rd_addr`  out  AW  RAM read address, valid with `read_en_o`.
- `count`  out  CW  occupancy, range 0..DEPTH.
- `full`  out  1  asserted when `count == DEPTH`.
- `empty`  out  1  asserted when `count == 0`.
- `overflow`  out  1  one-cycle pulse: a write was rejected.
- `underflow`  out  1  one-cycle pulse: a read was rejected.
- `almost_full`  out  1  asserted when `count >= AF_LEVEL` (macro only).
- `almost_empty`  out  1  asserted when `count <= AE_LEVEL` (macro only).

## Operation
- Internal state:
  - `wp`: next write slot, AW bits.
  - `rp`: next read slot, AW bits.
  - `count`: occupancy, CW bits.
- Acceptance is decided each cycle from the current registered state:
  - `rd_ok = read_en && !empty`.
  - `wr_ok = write_en && (!full || rd_ok)`. When full, a simultaneous read frees the slot, so the write is accepted.
- Accepted write:
  - `write_en_o <= 1`, `wr_addr <= wp`.
  - `wp <= (wp == DEPTH-1) ? 0 : wp+1`.
- Accepted read:
  - `read_en_o <= 1`, `rd_addr <= rp`.
  - `rp` wraps the same way as `wp`.
- Strobes deassert on any cycle with no accepted operation. Addresses hold their last value.
- Count update:
  - +1 on write only; −1 on read only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH and never drops below 0.
- `overflow <= write_en && !wr_ok`; `underflow <= read_en && !rd_ok`. Both are single-cycle pulses, not sticky.
- Empty with simultaneous read and write: the read is rejected (`underflow` pulses) and the write is accepted.
- `full`, `empty` and the almost flags are registered, derived from the next-state count, so they are coherent with `count` in the same cycle.
- Wrap-around arithmetic is explicit compare-to-`DEPTH-1`, never relying on natural binary overflow (required for non-power-of-two DEPTH).

## Timing
- All outputs are registered. Request in cycle N → strobe, address, count and flags valid in cycle N+1.
- Back-to-back requests are sustained at one per cycle per side.
- Reset values (reset low at a rising edge):
  - `wp = rp = 0`, `count = 0`.
  - `empty = 1`, `almost_empty = 1`.
  - All other outputs 0, including both addresses.
- Reset mid-operation discards occupancy immediately. Requests in the reset cycle are ignored and raise no error pulses.
- First edge with `reset` high processes requests normally.

## Configuration
- `FIFO_CTRL_ALMOST_EN` defined:
  - `AF_LEVEL`/`AE_LEVEL` thresholds are compiled in.
  - `almost_full`/`almost_empty` ports exist and are registered as described above.
- Not defined:
  - The ports are absent and the threshold comparators are not synthesised.
  - All other behaviour is identical.

## Structure
- Shared package `fifo_ctrl_pkg` holds:
  - Default `DEPTH`.
  - Width helper functions (`clog2`-based `AW`/`CW`).
  - The pointer-increment-with-wrap function.
- One sub-module `fifo_ptr_wrap`, parametrised on DEPTH and instantiated twice (write and read side):
  - Inputs: pointer register, advance enable.
  - Outputs: current pointer, next pointer.
- Count, flag and error logic live in the top module.

## Test plan
- Reset, then 4 writes at DEPTH=4 → `wr_addr` 0,1,2,3; `count` 1..4; `full = 1` in the cycle after the 4th write; `empty = 0` after the 1st.
- Full, write only → `overflow` pulses for 1 cycle; `write_en_o = 0`; `count` stays 4.
- Full, read+write together → both strobes; `rd_addr = 0`, `wr_addr = 0` (wrap); `count` stays 4; no overflow.
- Empty, read+write together → `underflow` pulse, `write_en_o = 1`, `count = 1`. Then a read alone → `rd_addr = 0`, `count = 0`, `empty = 1`.
- DEPTH=5: 12 alternating write/read pairs → addresses cycle 0..4,0..; no flags set. With the macro (AF_LEVEL=3, AE_LEVEL=1): `almost_full` at count 3, `almost_empty` at count ≤1.
- Reset low while `count = 3` with `write_en = 1` → next cycle `count = 0`, `empty = 1`, `write_en_o = 0`, no pulses.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and helpers for the FIFO pointer controller: default depth,
// pointer/count width functions and the wrap-aware pointer increment.
package fifo_ctrl_pkg;

  localparam int DEFAULT_DEPTH = 16;

  function automatic int aw_of(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cw_of(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit compare against depth-1 so non-power-of-two depths wrap correctly.
  function automatic int ptr_wrap_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_control_if.sv
// Request/strobe/status bundle between producer-consumer logic and the FIFO
// pointer controller. Almost flags exist only when FIFO_CTRL_ALMOST_EN is defined.
interface fifo_ptr_control_if
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = aw_of(DEPTH),
  parameter int CW    = cw_of(DEPTH)
);
  logic          write_en;
  logic          read_en;
  logic          write_en_o;
  logic [AW-1:0] wr_addr;
  logic          read_en_o;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;
`ifdef FIFO_CTRL_ALMOST_EN
  logic          almost_full;
  logic          almost_empty;
`endif

  modport master (
    output write_en, read_en,
    input  write_en_o, wr_addr, read_en_o, rd_addr, count, full, empty,
`ifdef FIFO_CTRL_ALMOST_EN
    input  almost_full, almost_empty,
`endif
    input  overflow, underflow
  );

  modport slave (
    input  write_en, read_en,
    output write_en_o, wr_addr, read_en_o, rd_addr, count, full, empty,
`ifdef FIFO_CTRL_ALMOST_EN
    output almost_full, almost_empty,
`endif
    output overflow, underflow
  );

endinterface

// File: rtl/fifo_ptr_wrap.sv
// Combinational pointer advance with explicit wrap at DEPTH-1; one instance
// per FIFO side.
module fifo_ptr_wrap
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = aw_of(DEPTH)
) (
  input  logic [AW-1:0] ptr,
  input  logic          adv,
  output logic [AW-1:0] cur,
  output logic [AW-1:0] nxt
);

  assign cur = ptr;
  assign nxt = adv ? AW'(ptr_wrap_inc(int'(ptr), DEPTH)) : ptr;

endmodule

// File: rtl/fifo_ptr_control.sv
// Pointer/occupancy controller for a single-clock circular FIFO.
// Optional almost-full/almost-empty flags are built when FIFO_CTRL_ALMOST_EN is defined.
module fifo_ptr_control
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AW       = aw_of(DEPTH),
  parameter int CW       = cw_of(DEPTH)
`ifdef FIFO_CTRL_ALMOST_EN
  ,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
`endif
) (
  input logic              clk,
  input logic              reset,
  fifo_ptr_control_if.slave bus
);

  logic [AW-1:0] wp, rp, wp_cur, rp_cur, wp_nxt, rp_nxt;
  logic [AW-1:0] wr_addr_q, rd_addr_q;
  logic [CW-1:0] count_q, count_nxt;
  logic          full_q, empty_q, wr_en_q, rd_en_q, ovf_q, udf_q;
  logic          rd_ok, wr_ok;

  // A read on a full FIFO frees the slot the concurrent write needs.
  assign rd_ok = bus.read_en && !empty_q;
  assign wr_ok = bus.write_en && (!full_q || rd_ok);

  fifo_ptr_wrap #(.DEPTH(DEPTH), .AW(AW)) u_wr_wrap (
    .ptr (wp),
    .adv (wr_ok),
    .cur (wp_cur),
    .nxt (wp_nxt)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH), .AW(AW)) u_rd_wrap (
    .ptr (rp),
    .adv (rd_ok),
    .cur (rp_cur),
    .nxt (rp_nxt)
  );

  always_comb begin
    count_nxt = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

`ifdef FIFO_CTRL_ALMOST_EN
  logic af_q, ae_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp        <= '0;
      rp        <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
`ifdef FIFO_CTRL_ALMOST_EN
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
`endif
    end else begin
      wp        <= wp_nxt;
      rp        <= rp_nxt;
      count_q   <= count_nxt;
      full_q    <= (count_nxt == CW'(DEPTH));
      empty_q   <= (count_nxt == '0);
      wr_en_q   <= wr_ok;
      rd_en_q   <= rd_ok;
      if (wr_ok) wr_addr_q <= wp_cur;
      if (rd_ok) rd_addr_q <= rp_cur;
      ovf_q     <= bus.write_en && !wr_ok;
      udf_q     <= bus.read_en && !rd_ok;
`ifdef FIFO_CTRL_ALMOST_EN
      af_q      <= (count_nxt >= CW'(AF_LEVEL));
      ae_q      <= (count_nxt <= CW'(AE_LEVEL));
`endif
    end
  end

  assign bus.write_en_o = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.read_en_o  = rd_en_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = udf_q;
`ifdef FIFO_CTRL_ALMOST_EN
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
`endif

endmodule
